// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Two-port arbiter in front of an asynchronous 8-bit SRAM.
//               Each transfer runs IDLE -> SETUP -> ACCESS x WAIT_CYCLES -> RECOVER.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter bit FIXED_PRIO  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        b_req,
    input  logic        a_we,
    input  logic        b_we,
    input  logic [20:0] a_addr,
    input  logic [20:0] b_addr,
    input  logic [7:0]  a_wdata,
    input  logic [7:0]  b_wdata,
    output logic [7:0]  a_rdata,
    output logic [7:0]  b_rdata,
    output logic        a_ack,
    output logic        b_ack,
    output logic [20:0] sram_addr,
    input  logic [7:0]  sram_din,
    output logic [7:0]  sram_dout,
    output logic        sram_dout_en,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    localparam logic [3:0] C_CNT_LOAD = 4'(WAIT_CYCLES - 1);

    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("sram_arbiter: WAIT_CYCLES=%0d is outside 1..15", WAIT_CYCLES);
        end
    endgenerate

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_lat_q, we_lat_d;
    logic        owner_q, owner_d;
    logic        busy_q, busy_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        dout_en_q, dout_en_d;
    logic [20:0] addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;
    logic [7:0]  a_rdata_q, a_rdata_d;
    logic [7:0]  b_rdata_q, b_rdata_d;
    logic        a_ack_q, a_ack_d;
    logic        b_ack_q, b_ack_d;

    logic        w_grant_b;
    logic        w_sel_we;

    // On a tie, round-robin hands the bus to whichever port did not own it last.
    assign w_grant_b = b_req & (~a_req | ((FIXED_PRIO == 1'b0) & ~owner_q));
    assign w_sel_we  = w_grant_b ? b_we : a_we;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_lat_d  = we_lat_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        ce_n_d    = ce_n_q;
        oe_n_d    = oe_n_q;
        we_n_d    = we_n_q;
        dout_en_d = dout_en_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    state_d   = ST_SETUP;
                    owner_d   = w_grant_b;
                    we_lat_d  = w_sel_we;
                    addr_d    = w_grant_b ? b_addr : a_addr;
                    ce_n_d    = 1'b0;
                    oe_n_d    = w_sel_we;
                    dout_en_d = w_sel_we;
                    busy_d    = 1'b1;
                    if (w_sel_we) begin
                        dout_d = w_grant_b ? b_wdata : a_wdata;
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = C_CNT_LOAD;
                we_n_d  = ~we_lat_q;
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RECOVER;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    a_ack_d = ~owner_q;
                    b_ack_d = owner_q;
                    // Read data is captured on the same edge that releases the strobes.
                    if (!we_lat_q) begin
                        if (owner_q) begin
                            b_rdata_d = sram_din;
                        end else begin
                            a_rdata_d = sram_din;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RECOVER: begin
                state_d   = ST_IDLE;
                dout_en_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            we_lat_q  <= 1'b0;
            owner_q   <= 1'b1;
            busy_q    <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            dout_en_q <= 1'b0;
            addr_q    <= 21'd0;
            dout_q    <= 8'd0;
            a_rdata_q <= 8'd0;
            b_rdata_q <= 8'd0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_lat_q  <= we_lat_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            dout_en_q <= dout_en_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
        end
    end

    assign a_rdata      = a_rdata_q;
    assign b_rdata      = b_rdata_q;
    assign a_ack        = a_ack_q;
    assign b_ack        = b_ack_q;
    assign sram_addr    = addr_q;
    assign sram_dout    = dout_q;
    assign sram_dout_en = dout_en_q;
    assign sram_ce_n    = ce_n_q;
    assign sram_oe_n    = oe_n_q;
    assign sram_we_n    = we_n_q;
    assign busy         = busy_q;
    assign owner        = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Directed self-checking bench; instance 0 W=2 round-robin,
//               1 W=2 fixed priority, 2 W=1, 3 W=15.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  a_req, b_req, a_we, b_we, a_ack, b_ack;
    logic [N-1:0]  dout_en, ce_n, oe_n, we_n, busy, owner;
    logic [20:0]   a_addr [N];
    logic [20:0]   b_addr [N];
    logic [20:0]   sram_addr [N];
    logic [7:0]    a_wdata [N];
    logic [7:0]    b_wdata [N];
    logic [7:0]    a_rdata [N];
    logic [7:0]    b_rdata [N];
    logic [7:0]    sram_din [N];
    logic [7:0]    sram_dout [N];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        sram_arbiter #(
            .WAIT_CYCLES((gi == 2) ? 1 : ((gi == 3) ? 15 : 2)),
            .FIXED_PRIO (gi == 1)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .a_req       (a_req[gi]),
            .b_req       (b_req[gi]),
            .a_we        (a_we[gi]),
            .b_we        (b_we[gi]),
            .a_addr      (a_addr[gi]),
            .b_addr      (b_addr[gi]),
            .a_wdata     (a_wdata[gi]),
            .b_wdata     (b_wdata[gi]),
            .a_rdata     (a_rdata[gi]),
            .b_rdata     (b_rdata[gi]),
            .a_ack       (a_ack[gi]),
            .b_ack       (b_ack[gi]),
            .sram_addr   (sram_addr[gi]),
            .sram_din    (sram_din[gi]),
            .sram_dout   (sram_dout[gi]),
            .sram_dout_en(dout_en[gi]),
            .sram_ce_n   (ce_n[gi]),
            .sram_oe_n   (oe_n[gi]),
            .sram_we_n   (we_n[gi]),
            .busy        (busy[gi]),
            .owner       (owner[gi])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-transfer observations filled in by do_xfer
    int         lat, ce_low, we_low, oe_low, viol, addr_bad, dout_bad, other_ack;
    logic [7:0] rd_at_ack;
    logic       rec_dout_en, dout_en_after, busy_after;

    task automatic do_xfer(input int d, input bit pb, input bit we,
                           input logic [20:0] addr, input logic [7:0] wd, input logic [7:0] din);
        lat = -1; ce_low = 0; we_low = 0; oe_low = 0; viol = 0;
        addr_bad = 0; dout_bad = 0; other_ack = 0; rd_at_ack = 8'h00; rec_dout_en = 1'b0;
        sram_din[d] = din;
        if (pb) begin
            b_req[d] = 1'b1; b_we[d] = we; b_addr[d] = addr; b_wdata[d] = wd;
        end else begin
            a_req[d] = 1'b1; a_we[d] = we; a_addr[d] = addr; a_wdata[d] = wd;
        end
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            tick();
            if (!ce_n[d]) begin
                ce_low++;
                if (sram_addr[d] !== addr) addr_bad++;
            end
            if (!we_n[d]) begin
                we_low++;
                if (sram_dout[d] !== wd || !dout_en[d]) dout_bad++;
            end
            if (!oe_n[d]) oe_low++;
            if ((!we_n[d] && !oe_n[d]) || (!we_n[d] && ce_n[d])) viol++;
            if (pb ? a_ack[d] : b_ack[d]) other_ack++;
            if (pb ? b_ack[d] : a_ack[d]) begin
                lat         = k;
                rd_at_ack   = pb ? b_rdata[d] : a_rdata[d];
                rec_dout_en = dout_en[d];
            end
        end
        a_req[d] = 1'b0;
        b_req[d] = 1'b0;
        tick();
        dout_en_after = dout_en[d];
        busy_after    = busy[d];
    endtask

    int ack_cyc [$];
    int ack_port[$];
    int na1, nb1, stray;

    initial begin
        reset = 1'b0;
        a_req = '0; b_req = '0; a_we = '0; b_we = '0;
        for (int i = 0; i < N; i++) begin
            a_addr[i] = '0; b_addr[i] = '0; a_wdata[i] = '0; b_wdata[i] = '0; sram_din[i] = '0;
        end
        tick();
        tick();
        check("rst_ce_n",    ce_n[0], 1);
        check("rst_oe_n",    oe_n[0], 1);
        check("rst_we_n",    we_n[0], 1);
        check("rst_dout_en", dout_en[0], 0);
        check("rst_addr",    sram_addr[0], 0);
        check("rst_dout",    sram_dout[0], 0);
        check("rst_rdata",   {a_rdata[0], b_rdata[0]}, 0);
        check("rst_ack",     {a_ack[0], b_ack[0]}, 0);
        check("rst_busy",    busy[0], 0);
        check("rst_owner",   owner[0], 1);
        reset = 1'b1;

        // A write, W=2
        do_xfer(0, 1'b0, 1'b1, 21'h1ABCD, 8'h5A, 8'h00);
        check("wr_lat",        lat, 4);
        check("wr_ce_low",     ce_low, 3);
        check("wr_we_low",     we_low, 2);
        check("wr_oe_low",     oe_low, 0);
        check("wr_viol",       viol, 0);
        check("wr_addr_bad",   addr_bad, 0);
        check("wr_dout_bad",   dout_bad, 0);
        check("wr_rec_douten", rec_dout_en, 1);
        check("wr_douten_aft", dout_en_after, 0);
        check("wr_busy_aft",   busy_after, 0);
        check("wr_a_rdata",    a_rdata[0], 8'h00);
        check("wr_owner",      owner[0], 0);
        check("wr_other_ack",  other_ack, 0);

        // B read, W=2
        do_xfer(0, 1'b1, 1'b0, 21'h00100, 8'h00, 8'hC3);
        check("rd_lat",       lat, 4);
        check("rd_oe_low",    oe_low, 3);
        check("rd_we_low",    we_low, 0);
        check("rd_addr_bad",  addr_bad, 0);
        check("rd_b_rdata",   rd_at_ack, 8'hC3);
        check("rd_a_rdata",   a_rdata[0], 8'h00);
        check("rd_other_ack", other_ack, 0);
        check("rd_owner",     owner[0], 1);

        // WAIT_CYCLES=1 and 15
        do_xfer(2, 1'b0, 1'b0, 21'h00055, 8'h00, 8'h81);
        check("w1_lat",    lat, 3);
        check("w1_ce_low", ce_low, 2);
        check("w1_rdata",  rd_at_ack, 8'h81);
        do_xfer(3, 1'b1, 1'b1, 21'h1FFFF, 8'hE7, 8'h00);
        check("w15_lat",      lat, 17);
        check("w15_ce_low",   ce_low, 16);
        check("w15_we_low",   we_low, 15);
        check("w15_viol",     viol, 0);
        check("w15_dout_bad", dout_bad, 0);

        // Both requesters held high: round-robin (inst 0) and fixed priority (inst 1)
        na1 = 0; nb1 = 0;
        for (int d = 0; d < 2; d++) begin
            a_req[d] = 1'b1; b_req[d] = 1'b1; a_we[d] = 1'b0; b_we[d] = 1'b0;
            sram_din[d] = 8'h77;
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (a_ack[0]) begin ack_cyc.push_back(k); ack_port.push_back(0); end
            if (b_ack[0]) begin ack_cyc.push_back(k); ack_port.push_back(1); end
            if (a_ack[1]) na1++;
            if (b_ack[1]) nb1++;
        end
        a_req[1:0] = 2'b00;
        b_req[1:0] = 2'b00;
        tick();
        tick();
        check("rr_count", ack_cyc.size(), 4);
        for (int i = 0; i < ack_cyc.size() && i < 4; i++) begin
            check($sformatf("rr_cyc%0d", i),  ack_cyc[i], 4 + 5 * i);
            check($sformatf("rr_port%0d", i), ack_port[i], i % 2);
        end
        check("fp_a_acks", na1, 4);
        check("fp_b_acks", nb1, 0);

        // Reset during the ACCESS phase of an A write
        a_req[0] = 1'b1; a_we[0] = 1'b1; a_addr[0] = 21'h0F0F0; a_wdata[0] = 8'hA5;
        tick();
        tick();
        check("mid_we_n_pre", we_n[0], 0);
        reset = 1'b0;
        #1;
        check("mid_we_n",    we_n[0], 1);
        check("mid_ce_n",    ce_n[0], 1);
        check("mid_dout_en", dout_en[0], 0);
        check("mid_ack",     a_ack[0], 0);
        a_req[0] = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        stray = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (a_ack[0] || busy[0]) stray++;
        end
        check("post_rst_stray", stray, 0);
        check("post_rst_busy",  busy[0], 0);
        check("post_rst_owner", owner[0], 1);
        do_xfer(0, 1'b0, 1'b0, 21'h0AAAA, 8'h00, 8'h3C);
        check("post_rd_lat",   lat, 4);
        check("post_rd_rdata", rd_at_ack, 8'h3C);
        do_xfer(0, 1'b0, 1'b1, 21'h00001, 8'h11, 8'hFF);
        check("post_wr_lat",   lat, 4);
        check("post_wr_rdata", a_rdata[0], 8'h3C);
        check("post_b_rdata",  b_rdata[0], 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
